twiddle_apply_row0: RTL and testbench

Streaming consumer of the row-0 horizontal twiddle-factor stream in the R16 16384-point NTT datapath. It multiplies each data word by its twiddle factor modulo the Goldilocks prime p = 2^64 − 2^32 + 1 (0xFFFFFFFF00000001) through a 4-stage pipeline. It also tags every result with the lane and twiddle-group index that the factor generator advances on. When stage_counter ≠ 0 the data passes through unmultiplied, with the same latency, so downstream timing is stage-independent.

---
 rtl/twiddle_apply_row0.sv | 194 +++++++++++++++++++
 tb/tb_twiddle_apply_row0.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/twiddle_apply_row0.sv
// twiddle_apply_row0: multiplies each data word by its twiddle factor modulo the
// Goldilocks prime through a 4-stage pipeline. Each result is tagged with the
// lane/group index. When stage_counter != 0, beats pass through unmultiplied
// with the same latency.
module twiddle_apply_row0 #(
    parameter int unsigned P_WIDTH  = 64,
    parameter int unsigned SC_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [P_WIDTH-1:0]  in_data,
    input  logic [P_WIDTH-1:0]  in_tf,
    input  logic [SC_WIDTH-1:0] stage_counter,
    output logic                out_valid,
    output logic [P_WIDTH-1:0]  out_data,
    output logic [3:0]          out_lane,
    output logic [5:0]          out_grp,
    output logic                busy
);

    localparam int unsigned HALF_W = P_WIDTH / 2;
    localparam int unsigned PROD_W = 2 * P_WIDTH;
    localparam int unsigned LANE_W = 4;
    localparam int unsigned GRP_W  = 6;

    // p = 2^64 - 2^32 + 1; EPS = 2^64 mod p = 2^32 - 1
    localparam logic [P_WIDTH-1:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    localparam logic [P_WIDTH-1:0] EPS   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [GRP_W-1:0]   GRP_RESET = GRP_W'(1);

    // Lane/group tag counters
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [GRP_W-1:0]  grp_q,  grp_d;

    // Stage 1: captured operands
    logic                v1_q, m1_q;
    logic [LANE_W-1:0]   lane1_q;
    logic [GRP_W-1:0]    grp1_q;
    logic [P_WIDTH-1:0]  a1_q, b1_q;

    // Stage 2: full product (or bypass operand in the low half)
    logic                v2_q, m2_q;
    logic [LANE_W-1:0]   lane2_q;
    logic [GRP_W-1:0]    grp2_q;
    logic [PROD_W-1:0]   prod2_q, prod2_d;

    // Stage 3: lo - hh partial, hl carried forward
    logic                v3_q, m3_q;
    logic [LANE_W-1:0]   lane3_q;
    logic [GRP_W-1:0]    grp3_q;
    logic [P_WIDTH-1:0]  t0_3_q, t0_3_d;
    logic [HALF_W-1:0]   hl3_q, hl3_d;

    // Stage 4: folded sum before the final conditional subtract
    logic                v4_q, m4_q;
    logic [LANE_W-1:0]   lane4_q;
    logic [GRP_W-1:0]    grp4_q;
    logic [P_WIDTH-1:0]  s4_q, s4_d;

    // Output
    logic [P_WIDTH-1:0]  res_d;
    logic                mode_c;

    // Mode capture and tag counter advance for accepted multiply beats
    always_comb begin
        mode_c = (stage_counter == '0);
        lane_d = lane_q;
        grp_d  = grp_q;
        if (in_valid && mode_c) begin
            lane_d = lane_q + LANE_W'(1);
            if (lane_q == {LANE_W{1'b1}}) begin
                grp_d = grp_q + GRP_W'(1);
            end
        end
    end

    // S1 -> S2: 128-bit product, or operand a in the low half for bypass
    always_comb begin
        prod2_d = {{P_WIDTH{1'b0}}, a1_q};
        if (m1_q) begin
            prod2_d = PROD_W'(a1_q) * PROD_W'(b1_q);
        end
    end

    // S2 -> S3: t0 = lo - hh, with the 2^64 wrap folded back by subtracting EPS
    always_comb begin
        logic [P_WIDTH-1:0] lo;
        logic [P_WIDTH-1:0] hh;
        logic [P_WIDTH-1:0] diff;
        lo     = prod2_q[P_WIDTH-1:0];
        hh     = P_WIDTH'(prod2_q[PROD_W-1:P_WIDTH+HALF_W]);
        diff   = lo - hh;
        t0_3_d = lo;
        hl3_d  = prod2_q[P_WIDTH+HALF_W-1:P_WIDTH];
        if (m2_q) begin
            t0_3_d = (lo < hh) ? (diff - EPS) : diff;
        end
    end

    // S3 -> S4: s = t0 + hl*(2^32-1), with a carry folded back by adding EPS
    always_comb begin
        logic [P_WIDTH-1:0] t1;
        logic [P_WIDTH:0]   sum;
        t1   = {hl3_q, {HALF_W{1'b0}}} - P_WIDTH'(hl3_q);
        sum  = {1'b0, t0_3_q} + {1'b0, t1};
        s4_d = t0_3_q;
        if (m3_q) begin
            s4_d = sum[P_WIDTH] ? (sum[P_WIDTH-1:0] + EPS) : sum[P_WIDTH-1:0];
        end
    end

    // S4 -> out: canonicalise into [0, p-1]; bypass beats are left untouched
    always_comb begin
        res_d = s4_q;
        if (m4_q && (s4_q >= P_MOD)) begin
            res_d = s4_q - P_MOD;
        end
    end

    // Pipeline valids, tags and data; async active-high reset discards in-flight beats
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            lane_q    <= '0;
            grp_q     <= GRP_RESET;
            v1_q      <= 1'b0;
            m1_q      <= 1'b0;
            lane1_q   <= '0;
            grp1_q    <= '0;
            a1_q      <= '0;
            b1_q      <= '0;
            v2_q      <= 1'b0;
            m2_q      <= 1'b0;
            lane2_q   <= '0;
            grp2_q    <= '0;
            prod2_q   <= '0;
            v3_q      <= 1'b0;
            m3_q      <= 1'b0;
            lane3_q   <= '0;
            grp3_q    <= '0;
            t0_3_q    <= '0;
            hl3_q     <= '0;
            v4_q      <= 1'b0;
            m4_q      <= 1'b0;
            lane4_q   <= '0;
            grp4_q    <= '0;
            s4_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= '0;
            out_grp   <= GRP_RESET;
            busy      <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            grp_q   <= grp_d;

            v1_q    <= in_valid;
            m1_q    <= mode_c;
            lane1_q <= lane_q;
            grp1_q  <= grp_q;
            a1_q    <= in_data;
            b1_q    <= in_tf;

            v2_q    <= v1_q;
            m2_q    <= m1_q;
            lane2_q <= lane1_q;
            grp2_q  <= grp1_q;
            prod2_q <= prod2_d;

            v3_q    <= v2_q;
            m3_q    <= m2_q;
            lane3_q <= lane2_q;
            grp3_q  <= grp2_q;
            t0_3_q  <= t0_3_d;
            hl3_q   <= hl3_d;

            v4_q    <= v3_q;
            m4_q    <= m3_q;
            lane4_q <= lane3_q;
            grp4_q  <= grp3_q;
            s4_q    <= s4_d;

            out_valid <= v4_q;
            if (v4_q) begin
                out_data <= res_d;
                out_lane <= lane4_q;
                out_grp  <= grp4_q;
            end

            busy <= in_valid | v1_q | v2_q | v3_q;
        end
    end

endmodule

// File: tb/tb_twiddle_apply_row0.sv
// Scoreboard bench for twiddle_apply_row0: directed vectors with hand-computed results.
module tb_twiddle_apply_row0;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [63:0] in_tf;
    logic [2:0]  stage_counter;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_lane;
    logic [5:0]  out_grp;
    logic        busy;

    twiddle_apply_row0 #(.P_WIDTH(64), .SC_WIDTH(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_tf         (in_tf),
        .stage_counter (stage_counter),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_lane      (out_lane),
        .out_grp       (out_grp),
        .busy          (busy)
    );

    typedef struct {
        logic [63:0] d;
        logic [3:0]  l;
        logic [5:0]  g;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    logic [3:0] m_lane = 4'd0;
    logic [5:0] m_grp  = 6'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop the oldest expectation whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_out: out_valid=1 with data 0x%016h but nothing expected", out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check64("out_data", out_data, e.d);
                check64("out_lane", 64'(out_lane), 64'(e.l));
                check64("out_grp",  64'(out_grp),  64'(e.g));
                check64("latency",  64'(cyc),      64'(e.cyc));
            end
        end
    end

    // Drive one beat and record its expected response (exp_mul used only for stage 0)
    task automatic issue(input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] sc, input logic [63:0] exp_mul);
        exp_t e;
        @(negedge clk);
        in_valid      = 1'b1;
        in_data       = a;
        in_tf         = b;
        stage_counter = sc;
        e.d   = (sc == 3'd0) ? exp_mul : a;
        e.l   = m_lane;
        e.g   = m_grp;
        e.cyc = cyc + 5;
        exp_q.push_back(e);
        if (sc == 3'd0) begin
            if (m_lane == 4'd15) m_grp = m_grp + 6'd1;
            m_lane = m_lane + 4'd1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (exp_q.size() != 0 && budget < 30) begin
            idle(1);
            budget++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        in_data       = '0;
        in_tf         = '0;
        stage_counter = '0;
        repeat (3) @(negedge clk);
        #1;
        check64("rst_out_valid", 64'(out_valid), 64'd0);
        check64("rst_out_data",  out_data,       64'd0);
        check64("rst_out_lane",  64'(out_lane),  64'd0);
        check64("rst_out_grp",   64'(out_grp),   64'd1);
        check64("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst_n = 1'b0;

        // Basic multiply and reduction corners
        issue(64'd2, 64'd3, 3'd0, 64'd6);
        @(posedge clk); #1;
        check64("busy_after_accept", 64'(busy), 64'd1);
        issue(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 3'd0, 64'd1);
        issue(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 3'd0, 64'h0000_0000_FFFF_FFFF);
        issue(64'h0001_0000_0000_0000, 64'h0001_0000_0000_0000, 3'd0, 64'hFFFF_FFFF_0000_0000);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd0, 64'h0000_0000_FFFF_FFFE);
        drain();
        check64("busy_idle", 64'(busy), 64'd0);

        // Streaming: continues the tag sequence, with a 2-cycle gap mid-stream
        for (int i = 0; i < 40; i++) begin
            issue(64'(i + 1), 64'(i + 2), 3'd0, 64'((i + 1) * (i + 2)));
            if (i == 19) idle(2);
        end
        drain();

        // Bypass, then switch to stage 0 back-to-back
        issue(64'hDEAD_BEEF_0000_0005, 64'd7, 3'd2, 64'd0);
        issue(64'd11, 64'd13, 3'd3, 64'd0);
        issue(64'd11, 64'd13, 3'd0, 64'd143);
        issue(64'd17, 64'd19, 3'd1, 64'd0);
        drain();

        // Group wrap: enough beats to pass grp 63 -> 0
        for (int i = 0; i < 1040; i++) begin
            issue(64'(i), 64'd3, 3'd0, 64'(3 * i));
        end
        drain();

        // Reset with 3 beats in flight
        issue(64'd100, 64'd100, 3'd0, 64'd10000);
        issue(64'd101, 64'd100, 3'd0, 64'd10100);
        issue(64'd102, 64'd100, 3'd0, 64'd10200);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check64("midrst_busy",      64'(busy),      64'd0);
        check64("midrst_out_valid", 64'(out_valid), 64'd0);
        exp_q.delete();
        m_lane = 4'd0;
        m_grp  = 6'd1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        idle(6);
        issue(64'd5, 64'd6, 3'd0, 64'd30);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule
